seq_scan_ctrl: RTL

//  Scan controller for the serial pattern detector. Accepts a programmed number of parallel words

---
 rtl/seq_scan_pkg.sv | 15 +
 rtl/seq_detect_core.sv | 68 ++++++
 rtl/seq_scan_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// Shared definitions for the scan controller: FSM states and the default detector pattern.
package seq_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } scan_state_e;

  localparam int unsigned DEF_PAT_LEN = 5;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10110;

endpackage

// File: rtl/seq_detect_core.sv
// Moore serial pattern detector; w is high while the state equals the full pattern length.
// SEQ_NONOVERLAP_EN: restart from the initial state after a match instead of reusing its bits.
module seq_detect_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned             PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]      PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic j,
  output logic w
);

  localparam int unsigned SW = $clog2(PAT_LEN + 1);

  logic [SW-1:0] st_q, st_d;

  // Bit n of the pattern counted from the first-received bit.
  function automatic logic pat_bit(input int unsigned n);
    logic [PAT_LEN-1:0] t;
    t = PATTERN << n;
    return t[PAT_LEN-1];
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length s, then b).
  function automatic logic [SW-1:0] step(input logic [SW-1:0] s, input logic b);
    int unsigned len;
    int unsigned best;
    logic        ok;
    logic        sb;
`ifdef SEQ_NONOVERLAP_EN
    len = (32'(s) == PAT_LEN) ? 1 : 32'(s) + 1;
`else
    len = 32'(s) + 1;
`endif
    best = 0;
    for (int unsigned k = 1; k <= PAT_LEN; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < PAT_LEN; i++) begin
          if (i < k) begin
            sb = (len - k + i == len - 1) ? b : pat_bit(len - k + i);
            if (sb != pat_bit(i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return SW'(best);
  endfunction

  always_comb begin
    st_d = st_q;
    if (clr)     st_d = '0;
    else if (en) st_d = step(st_q, j);
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= '0;
    else     st_q <= st_d;
  end

  assign w = (32'(st_q) == PAT_LEN);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: loads words over valid/ready, shifts them MSB-first into seq_detect_core
// and counts hits. Detector overlap behaviour selected by SEQ_NONOVERLAP_EN.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned        WORD_W  = 8,
  parameter int unsigned        CNT_W   = 8,
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_words,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              bit_out,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              done
);

  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  scan_state_e       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]        words_q, words_d;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic              consumed_q;
  logic              det_clr;
  logic              det_en;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          det_clr = 1'b1;
          if (num_words != '0) begin
            words_d = num_words;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          sreg_d    = in_data;
          bit_cnt_d = BW'(WORD_W - 1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_en = 1'b1;
        sreg_d = sreg_q << 1;
        if (bit_cnt_q == '0) begin
          if (words_q > 8'd1) begin
            words_d = words_q - 8'd1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FLUSH;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Count a hit only in the cycle right after a consumed bit, so a hit held through a
  // stalled LOAD (or into DONE/IDLE) is counted exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      words_q    <= '0;
      hit_cnt_q  <= '0;
      consumed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      words_q    <= words_d;
      consumed_q <= det_en;
      if (det_clr)
        hit_cnt_q <= '0;
      else if (hit && consumed_q && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  seq_detect_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .j   (sreg_q[WORD_W-1]),
    .w   (hit)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign bit_out   = (state_q == ST_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
  assign done      = (state_q == ST_DONE);
  assign hit_count = hit_cnt_q;

endmodule
